hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 16 +
 rtl/sat_counter16.sv | 34 +++
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared definitions for the pipeline hazard controller.
//   state_t      : controller FSM states (RUN / DRAIN / HALTED, encoding 3 illegal)
//   DRAIN_CYCLES : number of cycles spent in DRAIN before freezing
//   REG_ZERO     : architectural zero register index (never a real dependency)
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int         DRAIN_CYCLES = 3;
    localparam logic [4:0] REG_ZERO     = 5'd0;

endpackage

// File: rtl/sat_counter16.sv
// sat_counter16 -- 16-bit event counter that sticks at 16'hFFFF.
// Ports:
//   clk     : clock, counts on the rising edge
//   rst     : asynchronous active-low clear
//   inc_i   : count this cycle
//   count_o : current count
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- load-use stall, taken-branch flush and halt/drain control
// for a 5-stage pipeline.
// Optional feature macro: HAZARD_STATS_EN (adds saturating stall/flush counters).
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   i_ID_rs, i_ID_rt    : source register fields of the instruction in ID
//   i_EX_rt             : destination (rt) of the instruction in EX
//   i_EX_MemRead        : instruction in EX is a load
//   i_ID_Branch_Taken   : branch/jump resolved taken in ID
//   i_ID_Halt           : halt decoded in ID
//   i_Resume            : debug request to leave HALTED
//   o_Stall             : insert NOP into ID/EX
//   o_PC_Write          : PC update enable
//   o_IF_ID_Write       : IF/ID update enable
//   o_IF_ID_Flush       : clear IF/ID to NOP
//   o_Halted            : pipeline drained and frozen
//   o_State             : current FSM state
//   o_Stall_Count       : load-use stall cycles (HAZARD_STATS_EN only)
//   o_Flush_Count       : flush cycles (HAZARD_STATS_EN only)
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ID_rs,
    input  logic [4:0]  i_ID_rt,
    input  logic [4:0]  i_EX_rt,
    input  logic        i_EX_MemRead,
    input  logic        i_ID_Branch_Taken,
    input  logic        i_ID_Halt,
    input  logic        i_Resume,
    output logic        o_Stall,
    output logic        o_PC_Write,
    output logic        o_IF_ID_Write,
    output logic        o_IF_ID_Flush,
    output logic        o_Halted,
    output logic [1:0]  o_State
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] o_Stall_Count,
    output logic [15:0] o_Flush_Count
`endif
);

    // DRAIN is entered with the counter at DRAIN_CYCLES-1 and exits after it
    // reaches zero, giving exactly DRAIN_CYCLES cycles in DRAIN.
    localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;

    logic load_use;
    logic stall_c, pc_write_c, if_id_write_c, flush_c, halted_c;
    logic stall_evt;

    assign load_use = i_EX_MemRead && (i_EX_rt != REG_ZERO) &&
                      ((i_EX_rt == i_ID_rs) || (i_EX_rt == i_ID_rt));

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        stall_c       = 1'b0;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        flush_c       = 1'b0;
        halted_c      = 1'b0;
        stall_evt     = 1'b0;

        case (state_q)
            RUN: begin
                // Priority: load-use, then halt (wins over a same-cycle
                // branch), then taken branch.
                if (load_use) begin
                    stall_c       = 1'b1;
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    stall_evt     = 1'b1;
                end else if (i_ID_Halt) begin
                    // The halt itself moves on into EX; fetch is frozen.
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    state_d       = DRAIN;
                    drain_cnt_d   = DRAIN_LOAD;
                end else if (i_ID_Branch_Taken) begin
                    flush_c = 1'b1;
                end
            end

            DRAIN: begin
                stall_c       = 1'b1;
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                if (drain_cnt_q == 2'd0) begin
                    state_d = HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                end
            end

            HALTED: begin
                halted_c      = 1'b1;
                stall_c       = 1'b1;
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                if (i_Resume) begin
                    // Discard whatever sat in IF/ID while frozen and restart fetch.
                    flush_c    = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = RUN;
                end
            end

            default: begin
                // Illegal encoding: hold the pipeline for one cycle, recover to RUN.
                stall_c       = 1'b1;
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                state_d       = RUN;
                drain_cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            drain_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Control outputs are forced inactive while reset is held, including the
    // otherwise-combinational RUN defaults.
    assign o_Stall       = rst & stall_c;
    assign o_PC_Write    = rst & pc_write_c;
    assign o_IF_ID_Write = rst & if_id_write_c;
    assign o_IF_ID_Flush = rst & flush_c;
    assign o_Halted      = rst & halted_c;
    assign o_State       = state_q;

`ifdef HAZARD_STATS_EN
    logic stall_inc, flush_inc;
    assign stall_inc = rst & stall_evt;
    assign flush_inc = o_IF_ID_Flush;

    sat_counter16 u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_inc),
        .count_o (o_Stall_Count)
    );

    sat_counter16 u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (flush_inc),
        .count_o (o_Flush_Count)
    );
`else
    logic unused_stall_evt;
    assign unused_stall_evt = stall_evt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed self-checking bench for hazard_ctrl.
// Counter checks are compiled in only when HAZARD_STATS_EN is defined.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  i_ID_rs, i_ID_rt, i_EX_rt;
    logic        i_EX_MemRead, i_ID_Branch_Taken, i_ID_Halt, i_Resume;
    logic        o_Stall, o_PC_Write, o_IF_ID_Write, o_IF_ID_Flush, o_Halted;
    logic [1:0]  o_State;
`ifdef HAZARD_STATS_EN
    logic [15:0] o_Stall_Count, o_Flush_Count;
`endif

    int passed = 0;
    int total  = 0;
    int exp_stalls = 0;
    int exp_flush  = 0;

    hazard_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .i_ID_rs           (i_ID_rs),
        .i_ID_rt           (i_ID_rt),
        .i_EX_rt           (i_EX_rt),
        .i_EX_MemRead      (i_EX_MemRead),
        .i_ID_Branch_Taken (i_ID_Branch_Taken),
        .i_ID_Halt         (i_ID_Halt),
        .i_Resume          (i_Resume),
        .o_Stall           (o_Stall),
        .o_PC_Write        (o_PC_Write),
        .o_IF_ID_Write     (o_IF_ID_Write),
        .o_IF_ID_Flush     (o_IF_ID_Flush),
        .o_Halted          (o_Halted),
        .o_State           (o_State)
`ifdef HAZARD_STATS_EN
        ,
        .o_Stall_Count     (o_Stall_Count),
        .o_Flush_Count     (o_Flush_Count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are changed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_ID_rs = 5'd1; i_ID_rt = 5'd2; i_EX_rt = 5'd3;
        i_EX_MemRead = 1'b0; i_ID_Branch_Taken = 1'b0;
        i_ID_Halt = 1'b0; i_Resume = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #2;
        total++; if (o_State !== 2'd0) $display("FAIL rst_state got=%0d exp=0", o_State); else passed++;
        total++; if (o_PC_Write !== 1'b0) $display("FAIL rst_pcw got=%0b exp=0", o_PC_Write); else passed++;
        total++; if (o_IF_ID_Write !== 1'b0) $display("FAIL rst_ifidw got=%0b exp=0", o_IF_ID_Write); else passed++;
        total++; if (o_Stall !== 1'b0) $display("FAIL rst_stall got=%0b exp=0", o_Stall); else passed++;
        total++; if (o_IF_ID_Flush !== 1'b0) $display("FAIL rst_flush got=%0b exp=0", o_IF_ID_Flush); else passed++;
        total++; if (o_Halted !== 1'b0) $display("FAIL rst_halted got=%0b exp=0", o_Halted); else passed++;
`ifdef HAZARD_STATS_EN
        total++; if (o_Stall_Count !== 16'd0) $display("FAIL rst_scnt got=%0d exp=0", o_Stall_Count); else passed++;
        total++; if (o_Flush_Count !== 16'd0) $display("FAIL rst_fcnt got=%0d exp=0", o_Flush_Count); else passed++;
`endif
        @(negedge clk);
        rst = 1'b1;
        tick();
        $display("reset: done");
    endtask

    task automatic test_run_idle();
        idle_inputs();
        #1;
        total++; if (o_PC_Write !== 1'b1) $display("FAIL idle_pcw got=%0b exp=1", o_PC_Write); else passed++;
        total++; if (o_IF_ID_Write !== 1'b1) $display("FAIL idle_ifidw got=%0b exp=1", o_IF_ID_Write); else passed++;
        total++; if (o_Stall !== 1'b0) $display("FAIL idle_stall got=%0b exp=0", o_Stall); else passed++;
        total++; if (o_IF_ID_Flush !== 1'b0) $display("FAIL idle_flush got=%0b exp=0", o_IF_ID_Flush); else passed++;
        total++; if (o_Halted !== 1'b0) $display("FAIL idle_halted got=%0b exp=0", o_Halted); else passed++;
        tick();
        $display("run_idle: done");
    endtask

    task automatic test_load_use();
        // rs dependency on a load in EX
        idle_inputs();
        i_EX_MemRead = 1'b1; i_EX_rt = 5'd5; i_ID_rs = 5'd5;
        #1;
        total++; if (o_Stall !== 1'b1) $display("FAIL lu_rs_stall got=%0b exp=1", o_Stall); else passed++;
        total++; if (o_PC_Write !== 1'b0) $display("FAIL lu_rs_pcw got=%0b exp=0", o_PC_Write); else passed++;
        total++; if (o_IF_ID_Write !== 1'b0) $display("FAIL lu_rs_ifidw got=%0b exp=0", o_IF_ID_Write); else passed++;
        total++; if (o_IF_ID_Flush !== 1'b0) $display("FAIL lu_rs_flush got=%0b exp=0", o_IF_ID_Flush); else passed++;
        exp_stalls++;
        tick();
        idle_inputs();
        #1;
        total++; if (o_Stall !== 1'b0) $display("FAIL lu_after_stall got=%0b exp=0", o_Stall); else passed++;
`ifdef HAZARD_STATS_EN
        total++; if (o_Stall_Count !== 16'(exp_stalls)) $display("FAIL lu_scnt1 got=%0d exp=%0d", o_Stall_Count, exp_stalls); else passed++;
`endif
        // rt dependency
        i_EX_MemRead = 1'b1; i_EX_rt = 5'd9; i_ID_rt = 5'd9;
        #1;
        total++; if (o_Stall !== 1'b1) $display("FAIL lu_rt_stall got=%0b exp=1", o_Stall); else passed++;
        total++; if (o_PC_Write !== 1'b0) $display("FAIL lu_rt_pcw got=%0b exp=0", o_PC_Write); else passed++;
        exp_stalls++;
        tick();
        idle_inputs();
        // matching registers but not a load
        i_EX_MemRead = 1'b0; i_EX_rt = 5'd7; i_ID_rs = 5'd7;
        #1;
        total++; if (o_Stall !== 1'b0) $display("FAIL nolw_stall got=%0b exp=0", o_Stall); else passed++;
`ifdef HAZARD_STATS_EN
        total++; if (o_Stall_Count !== 16'(exp_stalls)) $display("FAIL lu_scnt2 got=%0d exp=%0d", o_Stall_Count, exp_stalls); else passed++;
`endif
        tick();
        $display("load_use: done");
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        i_EX_MemRead = 1'b1; i_EX_rt = 5'd0; i_ID_rt = 5'd0; i_ID_rs = 5'd0;
        #1;
        total++; if (o_Stall !== 1'b0) $display("FAIL zero_stall got=%0b exp=0", o_Stall); else passed++;
        total++; if (o_PC_Write !== 1'b1) $display("FAIL zero_pcw got=%0b exp=1", o_PC_Write); else passed++;
        tick();
        idle_inputs();
        $display("zero_reg: done");
    endtask

    task automatic test_branch_during_stall();
        idle_inputs();
        i_EX_MemRead = 1'b1; i_EX_rt = 5'd4; i_ID_rs = 5'd4; i_ID_Branch_Taken = 1'b1;
        #1;
        total++; if (o_Stall !== 1'b1) $display("FAIL bs_stall got=%0b exp=1", o_Stall); else passed++;
        total++; if (o_IF_ID_Flush !== 1'b0) $display("FAIL bs_noflush got=%0b exp=0", o_IF_ID_Flush); else passed++;
        exp_stalls++;
        tick();
        i_EX_MemRead = 1'b0;
        #1;
        total++; if (o_IF_ID_Flush !== 1'b1) $display("FAIL br_flush got=%0b exp=1", o_IF_ID_Flush); else passed++;
        total++; if (o_PC_Write !== 1'b1) $display("FAIL br_pcw got=%0b exp=1", o_PC_Write); else passed++;
        total++; if (o_Stall !== 1'b0) $display("FAIL br_stall got=%0b exp=0", o_Stall); else passed++;
        exp_flush++;
        tick();
        idle_inputs();
        #1;
        total++; if (o_IF_ID_Flush !== 1'b0) $display("FAIL br_oneshot got=%0b exp=0", o_IF_ID_Flush); else passed++;
`ifdef HAZARD_STATS_EN
        total++; if (o_Flush_Count !== 16'(exp_flush)) $display("FAIL br_fcnt got=%0d exp=%0d", o_Flush_Count, exp_flush); else passed++;
        total++; if (o_Stall_Count !== 16'(exp_stalls)) $display("FAIL br_scnt got=%0d exp=%0d", o_Stall_Count, exp_stalls); else passed++;
`endif
        tick();
        $display("branch_during_stall: done");
    endtask

    task automatic test_halt();
        idle_inputs();
        i_ID_Halt = 1'b1; i_ID_Branch_Taken = 1'b1;   // halt beats branch
        #1;
        total++; if (o_Stall !== 1'b0) $display("FAIL halt_stall got=%0b exp=0", o_Stall); else passed++;
        total++; if (o_PC_Write !== 1'b0) $display("FAIL halt_pcw got=%0b exp=0", o_PC_Write); else passed++;
        total++; if (o_IF_ID_Write !== 1'b0) $display("FAIL halt_ifidw got=%0b exp=0", o_IF_ID_Write); else passed++;
        total++; if (o_IF_ID_Flush !== 1'b0) $display("FAIL halt_noflush got=%0b exp=0", o_IF_ID_Flush); else passed++;
        tick();
        idle_inputs();
        i_Resume = 1'b1;   // must be ignored while draining
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (o_State !== 2'd1) $display("FAIL drain_state c=%0d got=%0d exp=1", c, o_State); else passed++;
            total++; if (o_PC_Write !== 1'b0) $display("FAIL drain_pcw c=%0d got=%0b exp=0", c, o_PC_Write); else passed++;
            total++; if (o_Stall !== 1'b1) $display("FAIL drain_stall c=%0d got=%0b exp=1", c, o_Stall); else passed++;
            total++; if (o_IF_ID_Flush !== 1'b0) $display("FAIL drain_flush c=%0d got=%0b exp=0", c, o_IF_ID_Flush); else passed++;
            tick();
        end
        i_Resume = 1'b0;
        #1;
        total++; if (o_State !== 2'd2) $display("FAIL halted_state got=%0d exp=2", o_State); else passed++;
        total++; if (o_Halted !== 1'b1) $display("FAIL halted_flag got=%0b exp=1", o_Halted); else passed++;
        total++; if (o_PC_Write !== 1'b0) $display("FAIL halted_pcw got=%0b exp=0", o_PC_Write); else passed++;
        total++; if (o_Stall !== 1'b1) $display("FAIL halted_stall got=%0b exp=1", o_Stall); else passed++;
        tick();
        #1;
        total++; if (o_State !== 2'd2) $display("FAIL halted_hold got=%0d exp=2", o_State); else passed++;
        $display("halt: done");
    endtask

    task automatic test_resume();
        i_Resume = 1'b1;
        #1;
        total++; if (o_IF_ID_Flush !== 1'b1) $display("FAIL res_flush got=%0b exp=1", o_IF_ID_Flush); else passed++;
        total++; if (o_PC_Write !== 1'b1) $display("FAIL res_pcw got=%0b exp=1", o_PC_Write); else passed++;
        exp_flush++;
        tick();
        i_Resume = 1'b0;
        #1;
        total++; if (o_State !== 2'd0) $display("FAIL res_state got=%0d exp=0", o_State); else passed++;
        total++; if (o_Halted !== 1'b0) $display("FAIL res_halted got=%0b exp=0", o_Halted); else passed++;
        total++; if (o_PC_Write !== 1'b1) $display("FAIL res_run_pcw got=%0b exp=1", o_PC_Write); else passed++;
`ifdef HAZARD_STATS_EN
        total++; if (o_Flush_Count !== 16'(exp_flush)) $display("FAIL res_fcnt got=%0d exp=%0d", o_Flush_Count, exp_flush); else passed++;
`endif
        tick();
        $display("resume: done");
    endtask

    task automatic test_reset_mid_drain();
        idle_inputs();
        i_ID_Halt = 1'b1;
        tick();            // now DRAIN, drain_cnt=2
        idle_inputs();
        tick();            // DRAIN, drain_cnt=1
        #1;
        total++; if (o_State !== 2'd1) $display("FAIL mid_pre_state got=%0d exp=1", o_State); else passed++;
        rst = 1'b0;        // between edges: must act without a clock
        #1;
        total++; if (o_State !== 2'd0) $display("FAIL mid_state got=%0d exp=0", o_State); else passed++;
        total++; if (o_Stall !== 1'b0) $display("FAIL mid_stall got=%0b exp=0", o_Stall); else passed++;
        total++; if (o_PC_Write !== 1'b0) $display("FAIL mid_pcw got=%0b exp=0", o_PC_Write); else passed++;
        total++; if (o_IF_ID_Write !== 1'b0) $display("FAIL mid_ifidw got=%0b exp=0", o_IF_ID_Write); else passed++;
        total++; if (o_Halted !== 1'b0) $display("FAIL mid_halted got=%0b exp=0", o_Halted); else passed++;
        exp_stalls = 0;
        exp_flush  = 0;
`ifdef HAZARD_STATS_EN
        total++; if (o_Stall_Count !== 16'd0) $display("FAIL mid_scnt got=%0d exp=0", o_Stall_Count); else passed++;
        total++; if (o_Flush_Count !== 16'd0) $display("FAIL mid_fcnt got=%0d exp=0", o_Flush_Count); else passed++;
`endif
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        #1;
        total++; if (o_State !== 2'd0) $display("FAIL post_state got=%0d exp=0", o_State); else passed++;
        total++; if (o_PC_Write !== 1'b1) $display("FAIL post_pcw got=%0b exp=1", o_PC_Write); else passed++;
        $display("reset_mid_drain: done");
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_saturation();
        idle_inputs();
        i_EX_MemRead = 1'b1; i_EX_rt = 5'd12; i_ID_rs = 5'd12;
        repeat (65536) tick();
        #1;
        total++; if (o_Stall_Count !== 16'hFFFF) $display("FAIL sat_scnt got=%h exp=ffff", o_Stall_Count); else passed++;
        tick();
        #1;
        total++; if (o_Stall_Count !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", o_Stall_Count); else passed++;
        idle_inputs();
        tick();
        $display("saturation: done");
    endtask
`endif

    initial begin
        test_reset();
        test_run_idle();
        test_load_use();
        test_zero_reg();
        test_branch_during_stall();
        test_halt();
        test_resume();
        test_reset_mid_drain();
`ifdef HAZARD_STATS_EN
        test_saturation();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
